// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store unit: the controller state
//   encoding and the default memory geometry/latency used when the unit
//   is instantiated without overrides.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        ERR     = 3'd4,
        RESP    = 3'd5
    } lsu_state_t;

    localparam int LSU_DEPTH  = 8;
    localparam int LSU_RD_LAT = 1;

endpackage

// File: rtl/load_store_unit.sv
// load_store_unit
//   Turns single load/store requests from the execute stage into the
//   strobe protocol of a word-addressed data memory with a registered read
//   port. One transaction is in flight at a time; out-of-range addresses
//   are answered with an error response and never reach the memory.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
//   both high. The requester holds req_* stable while req_valid is high and
//   req_ready is low; the unit holds resp_* stable while resp_valid is high
//   and resp_ready is low.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_addr, req_wdata  word address and store data
//   resp_valid/ready     response handshake
//   resp_rdata           load data (0 for stores and errors)
//   resp_err             address was >= DEPTH
//   mem_r_en, mem_w_en   one-cycle memory strobes (never both high)
//   mem_adr, mem_wdata   captured address/data, held until next acceptance
//   mem_rdata            memory read data, valid RD_LAT cycles after the
//                        edge that samples mem_r_en
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = LSU_DEPTH,
    parameter int RD_LAT = LSU_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    lsu_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              addr_oob;

    // Unsigned compare over the full address width: large addresses must
    // not alias onto valid words.
    assign addr_oob  = (req_addr >= ADDR_W'(DEPTH));

    // Only output that is decoded rather than registered.
    assign req_ready = (state == IDLE);

    // The store/load direction is not kept in a separate register: it is
    // fully encoded by which of RD/WR/ERR the acceptance edge selects.
    // Strobes are raised on the acceptance edge itself so that they are
    // registered outputs and still appear in the cycle right after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_adr   <= req_addr;
                        mem_wdata <= req_wdata;
                        if (addr_oob) begin
                            state <= ERR;
                        end else if (req_we) begin
                            state    <= WR;
                            mem_w_en <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_r_en <= 1'b1;
                        end
                    end
                end

                WR: begin
                    mem_w_en   <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end

                RD: begin
                    // The memory samples mem_r_en on the edge leaving RD;
                    // data is then valid RD_LAT edges later.
                    mem_r_en <= 1'b0;
                    wait_cnt <= CNT_W'(RD_LAT - 1);
                    state    <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        resp_rdata <= mem_rdata;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                ERR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller that turns single load/store requests from the processor datapath into the strobe-level protocol the word-addressed data memory expects: one-cycle `mem_r_en`/`mem_w_en` pulses, an address, and write data. It waits out the memory's registered read latency and returns read data or a write acknowledge on a valid/ready response channel. It sits between the execute stage and the data memory, handles one transaction at a time, and flags out-of-range addresses without touching memory.

## Interface
- `ADDR_W`, 32, request/memory address width (word index).
- `DATA_W`, 32, data width.
- `DEPTH`, 8, number of memory words; valid addresses are 0..DEPTH-1.
- `RD_LAT`, 1, cycles from the edge that samples `mem_r_en` until `mem_rdata` is valid (≥1).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  DATA_W  load data (0 for stores/errors).
- `resp_err`  out  1  address ≥ DEPTH.
- `mem_r_en`  out  1  memory read strobe.
- `mem_w_en`  out  1  memory write strobe.
- `mem_adr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- FSM states: IDLE, RD, RD_WAIT, WR, ERR, RESP.
- IDLE: `req_ready`=1. Handshake on `req_valid && req_ready` captures addr/we/wdata. Next state: ERR if addr ≥ DEPTH, else WR if `req_we`, else RD.
- WR: `mem_w_en`=1 for exactly one cycle with `mem_adr`/`mem_wdata` driven from the captured values; → RESP with rdata=0, err=0.
- RD: `mem_r_en`=1 for exactly one cycle; → RD_WAIT, wait counter loaded with RD_LAT-1.
- RD_WAIT: counts down; when counter = 0, capture `mem_rdata` into `resp_rdata`; → RESP.
- ERR: no memory strobe; → RESP with err=1, rdata=0.
- RESP: `resp_valid`=1, data/err held stable until `resp_ready`; on handshake → IDLE.
- `req_ready`=0 in every state except IDLE. Only one transaction is outstanding, with no pipelining.
- `mem_r_en` and `mem_w_en` are never high in the same cycle. `mem_adr`/`mem_wdata` hold the captured values from acceptance until the next acceptance.
- Address comparison is unsigned over the full ADDR_W. No wrap or truncation to log2(DEPTH).

## Timing
- Reset (async on `rst_n` low): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_r_en`=0, `mem_w_en`=0, `mem_adr`=0, `mem_wdata`=0. Strobes drop immediately, without waiting for a clock.
- Reset mid-transaction aborts it. No response is issued and no further strobe follows.
- All outputs except `req_ready` are registered. `req_ready` decodes the state register.
- Request accepted at edge E0:
  - Store: `mem_w_en` high in E0→E1, `resp_valid` high from E1.
  - Load: `mem_r_en` high in E0→E1, data sampled at edge E1+RD_LAT, `resp_valid` high from that edge. With RD_LAT=1, `resp_valid` is high from E2.
  - Error: `resp_valid` high from E1.
- Back-to-back: the earliest next acceptance is the edge after the RESP handshake, so store throughput is 1 per 3 cycles with `resp_ready` held at 1.
- `resp_ready` low stalls indefinitely in RESP. `req_valid` during non-IDLE states is ignored; the requester holds it.

## Structure
- Package `lsu_pkg`: the FSM state enum (`lsu_state_t`) and default constants `LSU_DEPTH`=8 and `LSU_RD_LAT`=1.
- Single module. The RD_LAT counter is inline, sized $clog2(RD_LAT+1), so no sub-module is needed.

## Test plan
- Load: memory preloaded word 2 = 3. Send load addr 2 → `mem_r_en` pulses once with `mem_adr`=2, `resp_valid` 2 cycles after acceptance, `resp_rdata`=3, `resp_err`=0.
- Store then load: store 0xA5 to addr 5, then load addr 5 → exactly one `mem_w_en` pulse with `mem_wdata`=0xA5, write ack rdata=0, subsequent load returns 0xA5.
- Out of range: load addr 8, then store addr 0xFFFF_FFFF → no strobes, each response has `resp_err`=1, rdata=0, one cycle after acceptance.
- Backpressure: hold `resp_ready`=0 for 5 cycles after a load of addr 7 (=7) → `resp_valid`/`resp_rdata`=7 stable throughout, `req_ready`=0 and a concurrent `req_valid` not accepted.
- Reset mid-read: deassert `rst_n` the cycle `mem_r_en` is high → strobe low immediately, no `resp_valid` after reset release, `req_ready`=1.
- RD_LAT=3 build: load addr 1 (=2) → `resp_valid` 4 cycles after acceptance, rdata=2.
